// File: rtl/mult_pkg.sv
// Shared encodings for the sequential 8x8 multiplier: FSM states, operand
// nibble selects, shifter controls and the cycle-counter width.
package mult_pkg;

  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LSB  = 3'b001,
    MID  = 3'b010,
    MSB  = 3'b011,
    DONE = 3'b100,
    ERR  = 3'b101
  } state_t;

  localparam logic [1:0] SEL_LL = 2'b00;
  localparam logic [1:0] SEL_LH = 2'b01;
  localparam logic [1:0] SEL_HL = 2'b10;
  localparam logic [1:0] SEL_HH = 2'b11;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Sequencing FSM for the 8x8 multiplier: walks the four nibble products,
// cross-checks the external cycle counter and owns that counter's clear.
module mult_ctrl_fsm #(
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_clr_n,
  output logic [1:0]       input_sel,
  output logic [1:0]       shift_sel,
  output logic             acc_en,
  output logic             acc_load,
  output logic [2:0]       state_out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import mult_pkg::*;

  if (CNT_W != 2) begin : g_bad_cnt_w
    $error("mult_ctrl_fsm: CNT_W must be 2");
  end

  state_t r_state;
  state_t w_next;
  logic   r_cnt_clr_n;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= IDLE;
      r_cnt_clr_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Counter runs only while the next state is a product cycle, so it
      // leaves reset at the start edge and reads 0 throughout LSB.
      r_cnt_clr_n <= (w_next == LSB) || (w_next == MID) || (w_next == MSB);
    end
  end

  always_comb begin
    w_next    = r_state;
    input_sel = SEL_LL;
    shift_sel = SH0;
    acc_en    = 1'b0;
    acc_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = LSB;
      end
      LSB: begin
        acc_en   = 1'b1;
        acc_load = 1'b1;
        w_next   = (count == CNT_W'(0)) ? MID : ERR;
      end
      MID: begin
        // MID covers both cross products; count picks which one.
        if (count == CNT_W'(1)) begin
          input_sel = SEL_LH;
          shift_sel = SH4;
          acc_en    = 1'b1;
        end else if (count == CNT_W'(2)) begin
          input_sel = SEL_HL;
          shift_sel = SH4;
          acc_en    = 1'b1;
          w_next    = MSB;
        end else begin
          w_next = ERR;
        end
      end
      MSB: begin
        if (count == CNT_W'(3)) begin
          input_sel = SEL_HH;
          shift_sel = SH8;
          acc_en    = 1'b1;
          w_next    = DONE;
        end else begin
          w_next = ERR;
        end
      end
      DONE: begin
        if (!start) w_next = IDLE;
      end
      ERR: begin
        if (!start) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign cnt_clr_n = r_cnt_clr_n;
  assign state_out = r_state;
  assign busy      = (r_state == LSB) || (r_state == MID) || (r_state == MSB);
  assign done      = (r_state == DONE);
  assign err       = (r_state == ERR);

endmodule
